// File: rtl/z80_io_bridge.sv
// z80_io_bridge: synchronous Z80 I/O front end that decodes port hits, strobes writes and drives read-back data.
// IORQ/M1/RD/WR are synchronised; A_L/D_IN are sampled only after the settle count has run.
module z80_io_bridge #(
    parameter logic [7:0]  BASE_ADDR     = 8'h10,
    parameter logic [7:0]  ADDR_MASK     = 8'hFC,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       CLK_24MHz,
    input  logic       RES,
    input  logic       IORQ,
    input  logic       M1,
    input  logic       RD,
    input  logic       WR,
    input  logic [7:0] A_L,
    input  logic [7:0] D_IN,
    output logic [7:0] D_OUT,
    output logic       D_OE,
    output logic       wr_stb,
    output logic [1:0] wr_port,
    output logic [7:0] wr_data,
    output logic [1:0] rd_port,
    input  logic [7:0] rd_data,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, W_SETTLE, W_HOLD, R_SETTLE, R_DRIVE} state_t;

    localparam logic [2:0] SETTLE = 3'(SETTLE_CYCLES);

    logic [SYNC_STAGES-1:0][3:0] sync_q;
    state_t                      state_q;
    logic [2:0]                  cnt_q;
    logic                        wr_stb_q;
    logic                        d_oe_q;
    logic [1:0]                  wr_port_q;
    logic [7:0]                  wr_data_q;
    logic [1:0]                  rd_port_q;
    logic                        iorq_s, m1_s, rd_s, wr_s;
    logic                        hit, wq, rq, done;
    logic [2:0]                  cnt_inc;

    // Stage 0 is the newest sample; the oldest stage feeds the decode.
    always_ff @(posedge CLK_24MHz or negedge RES)
        if (!RES) sync_q <= '1;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], IORQ, M1, RD, WR};

    assign {iorq_s, m1_s, rd_s, wr_s} = sync_q[SYNC_STAGES-1];
    assign hit     = (A_L & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
    assign wq      = ~iorq_s & ~wr_s & m1_s & hit;
    assign rq      = ~iorq_s & ~rd_s & m1_s & hit;
    assign done    = cnt_q == SETTLE;
    assign cnt_inc = cnt_q + {2'b00, cnt_q != 3'd7};

    always_ff @(posedge CLK_24MHz or negedge RES) begin
        if (!RES) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_stb_q  <= 1'b0;
            d_oe_q    <= 1'b0;
            wr_port_q <= '0;
            wr_data_q <= '0;
            rd_port_q <= '0;
        end else begin
            wr_stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wq) begin
                        state_q <= W_SETTLE;
                        cnt_q   <= 3'd1;
                    end else if (rq) begin
                        state_q <= R_SETTLE;
                        cnt_q   <= 3'd1;
                    end
                end
                W_SETTLE: begin
                    if (!wq) state_q <= IDLE;
                    else if (done) begin
                        wr_stb_q  <= 1'b1;
                        wr_port_q <= A_L[1:0];
                        wr_data_q <= D_IN;
                        state_q   <= W_HOLD;
                    end else cnt_q <= cnt_inc;
                end
                W_HOLD: if (iorq_s && wr_s) state_q <= IDLE;
                R_SETTLE: begin
                    if (!rq) state_q <= IDLE;
                    else if (done) begin
                        rd_port_q <= A_L[1:0];
                        d_oe_q    <= 1'b1;
                        state_q   <= R_DRIVE;
                    end else cnt_q <= cnt_inc;
                end
                R_DRIVE: begin
                    if (iorq_s || rd_s) begin
                        d_oe_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    d_oe_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_stb  = wr_stb_q;
    assign wr_port = wr_port_q;
    assign wr_data = wr_data_q;
    assign rd_port = rd_port_q;
    assign D_OE    = d_oe_q;
    assign D_OUT   = d_oe_q ? rd_data : 8'h00;
    assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_z80_io_bridge.sv
// tb_z80_io_bridge: table-driven Z80 I/O cycles plus hand-written glitch, pulse-length and reset sequences.
module tb_z80_io_bridge;
    logic       CLK_24MHz = 1'b0;
    logic       RES = 1'b0;
    logic       IORQ = 1'b1, M1 = 1'b1, RD = 1'b1, WR = 1'b1;
    logic [7:0] A_L = 8'h00, D_IN = 8'h00, rd_data = 8'h00;
    logic [7:0] D_OUT, wr_data;
    logic       D_OE, wr_stb, busy;
    logic [1:0] wr_port, rd_port;

    int tests = 0, fails = 0;
    int cyc = 0;
    int stb_total = 0, stb_cyc = 0;
    logic [1:0] stb_port = 2'd0;
    logic [7:0] stb_data = 8'h00;

    z80_io_bridge dut (
        .CLK_24MHz(CLK_24MHz), .RES(RES), .IORQ(IORQ), .M1(M1), .RD(RD), .WR(WR),
        .A_L(A_L), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .wr_stb(wr_stb),
        .wr_port(wr_port), .wr_data(wr_data), .rd_port(rd_port), .rd_data(rd_data), .busy(busy)
    );

    always #20 CLK_24MHz = ~CLK_24MHz;

    always @(posedge CLK_24MHz) cyc <= cyc + 1;

    always @(negedge CLK_24MHz)
        if (wr_stb) begin
            stb_total = stb_total + 1;
            stb_cyc   = cyc;
            stb_port  = wr_port;
            stb_data  = wr_data;
        end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge CLK_24MHz);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rdv;
        logic       wr;
        logic       m1;
        logic       exp_stb;
        logic       exp_oe;
        logic [1:0] exp_port;
    } vec_t;

    vec_t v[11];

    initial begin
        int base, start;
        //          addr   data   rdv    wr  m1  stb oe  port
        v[0]  = '{8'h12, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
        v[1]  = '{8'h14, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        v[2]  = '{8'h0F, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3};
        v[3]  = '{8'h10, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
        v[4]  = '{8'h10, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
        v[5]  = '{8'h13, 8'h00, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3};
        v[6]  = '{8'h10, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
        v[7]  = '{8'h10, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
        v[8]  = '{8'h11, 8'h41, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
        v[9]  = '{8'h12, 8'h22, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2};
        v[10] = '{8'h13, 8'h63, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3};

        ticks(2);
        check("rst_busy", busy, 0);
        check("rst_oe", D_OE, 0);
        check("rst_stb", wr_stb, 0);
        check("rst_dout", D_OUT, 0);
        check("rst_wr_port", wr_port, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_port", rd_port, 0);
        RES = 1'b1;
        ticks(2);

        for (int i = 0; i < 11; i++) begin
            base = stb_total;
            A_L = v[i].addr; D_IN = v[i].data; rd_data = v[i].rdv; M1 = v[i].m1;
            IORQ = 1'b0;
            if (v[i].wr) WR = 1'b0; else RD = 1'b0;
            start = cyc;
            ticks(40);
            check($sformatf("v%0d_busy_hold", i), busy, v[i].exp_stb | v[i].exp_oe);
            check($sformatf("v%0d_oe", i), D_OE, v[i].exp_oe);
            if (v[i].exp_oe) begin
                check($sformatf("v%0d_dout", i), D_OUT, v[i].rdv);
                check($sformatf("v%0d_rd_port", i), rd_port, v[i].exp_port);
            end
            if (v[i].exp_stb) begin
                check_range($sformatf("v%0d_latency", i), stb_cyc - start, 4, 5);
                check($sformatf("v%0d_wr_port", i), stb_port, v[i].exp_port);
                check($sformatf("v%0d_wr_data", i), stb_data, v[i].data);
                check($sformatf("v%0d_held_port", i), wr_port, v[i].exp_port);
                check($sformatf("v%0d_held_data", i), wr_data, v[i].data);
            end
            IORQ = 1'b1; WR = 1'b1; RD = 1'b1; M1 = 1'b1;
            ticks(3);
            check($sformatf("v%0d_oe_drop", i), D_OE, 0);
            ticks(5);
            check($sformatf("v%0d_busy_idle", i), busy, 0);
            check($sformatf("v%0d_stb_count", i), stb_total - base, v[i].exp_stb);
        end

        // one-clock write glitch must be rejected
        base = stb_total;
        A_L = 8'h11; D_IN = 8'hEE; IORQ = 1'b0; WR = 1'b0;
        ticks(1);
        IORQ = 1'b1; WR = 1'b1;
        ticks(6);
        check("glitch_no_stb", stb_total - base, 0);
        check("glitch_idle", busy, 0);
        check("glitch_data_held", wr_data, 8'h63);

        // pulse exactly SYNC_STAGES+SETTLE_CYCLES clocks long still strobes once
        base = stb_total;
        D_IN = 8'h99; IORQ = 1'b0; WR = 1'b0;
        ticks(4);
        IORQ = 1'b1; WR = 1'b1;
        ticks(8);
        check("pulse_stb", stb_total - base, 1);
        check("pulse_data", stb_data, 8'h99);
        check("pulse_port", stb_port, 1);
        check("pulse_idle", busy, 0);

        // reset during R_DRIVE, with a live rd_data change first
        A_L = 8'h10; rd_data = 8'h11; IORQ = 1'b0; RD = 1'b0;
        ticks(10);
        check("rdrv_oe", D_OE, 1);
        rd_data = 8'h3C;
        #1;
        check("rdrv_pass", D_OUT, 8'h3C);
        RES = 1'b0;
        #1;
        check("rdrv_rst_oe", D_OE, 0);
        check("rdrv_rst_dout", D_OUT, 0);
        check("rdrv_rst_busy", busy, 0);
        ticks(1);
        check("rdrv_rst_oe_edge", D_OE, 0);
        IORQ = 1'b1; RD = 1'b1; RES = 1'b1;
        ticks(4);
        check("rdrv_after_idle", busy, 0);

        // reset during W_HOLD, write still active after release
        base = stb_total;
        A_L = 8'h12; D_IN = 8'hAA; IORQ = 1'b0; WR = 1'b0;
        ticks(10);
        check("whold_stb", stb_total - base, 1);
        check("whold_busy", busy, 1);
        RES = 1'b0;
        #1;
        check("whold_rst_busy", busy, 0);
        check("whold_rst_stb", wr_stb, 0);
        check("whold_rst_oe", D_OE, 0);
        check("whold_rst_port", wr_port, 0);
        check("whold_rst_data", wr_data, 0);
        ticks(2);
        base = stb_total;
        D_IN = 8'hB7;
        RES = 1'b1;
        start = cyc;
        ticks(3);
        check("whold_no_early_stb", stb_total - base, 0);
        ticks(9);
        check("whold_restb", stb_total - base, 1);
        check_range("whold_restb_latency", stb_cyc - start, 4, 5);
        check("whold_restb_data", stb_data, 8'hB7);
        IORQ = 1'b1; WR = 1'b1;
        ticks(6);
        check("whold_end_idle", busy, 0);
        check("whold_end_count", stb_total - base, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
